mdv_iter_unit: RTL and testbench
================================

Name: mdv_iter_unit

Overview:
- Parametrised multiply-add / divide unit for the arithmetic datapath; next generation of the fixed 16-bit multiply/divide store.
- Operand width is generic, and the unit has an explicit start/busy/done handshake.
- Multiply is iterative shift-add; divide is iterative restoring with an overflow pre-check.
- Results stay registered until the next completion, so accumulator write-back can be taken at any time after o_done.

Parameters:
W, 16, operand width in bits (minimum 2); results are 2W split into hi/lo.

Ports:
clk  in  1  clock; all state changes on rising edge
rstn_CHJ  in  1  reset, asynchronous, active-low
i_start  in  1  request; sampled only in IDLE
i_op  in  1  1 = multiply-add, 0 = divide
i_a  in  W  MUL: addend; DIV: dividend high word
i_b  in  W  MUL: multiplicand; DIV: dividend low word
i_c  in  W  MUL: multiplier; DIV: divisor
i_cin  in  1  carry-in, passed through on multiply
o_busy  out  1  high in MUL/DIV states
o_done  out  1  one-cycle completion pulse (DONE state)
o_hi  out  W  MUL: product high word; DIV: remainder (or i_a on overflow)
o_lo  out  W  MUL: product low word; DIV: quotient (or i_b on overflow)
o_cout  out  1  MUL: i_cin; DIV: 1 = overflow, 0 = normal

Behaviour:
- Reset (async, any state): state IDLE; counter, working registers and o_hi/o_lo/o_cout = 0; o_busy = 0, o_done = 0. An operation in progress is abandoned and produces no o_done.
- States: IDLE, MUL, DIV, DONE.
- Accept edge E0: state IDLE and i_start = 1.
  - Latch i_a, i_b, i_c, i_cin and i_op into working registers.
  - Go to MUL or DIV; counter = 0.
  - Inputs are don't-care after E0.
- i_start outside IDLE, including the DONE cycle, is ignored; there is no queueing.
- MUL: result = i_b * i_c + i_a, computed to 2W bits (never overflows, since max = 2^2W - 2^W).
  - One shift-add step per edge, E1..EW.
  - At EW: result loaded into o_hi/o_lo, o_cout = latched cin, go to DONE.
  - o_done is high in the cycle after EW (W edges after accept).
- DIV: dividend D = {i_a, i_b}, divisor V = i_c.
  - Overflow when i_a >= i_c (this includes i_c = 0).
  - Overflow, at E1: o_hi = i_a, o_lo = i_b, o_cout = 1, go to DONE (no iterations).
  - Normal: restoring division, one quotient bit per edge, E1..EW, MSB first.
  - Each step: trial-subtract the shifted divisor; keep the difference if non-negative; shift in the quotient bit.
  - At EW: o_lo = quotient, o_hi = remainder (< V), o_cout = 0, go to DONE.
- DONE: o_done = 1 and o_busy = 0 for exactly one cycle, then IDLE. A new accept is possible on the edge that leaves IDLE, i.e. the second edge after DONE.
- o_hi/o_lo/o_cout change only on entry to DONE (or on reset); they hold through IDLE and through the next operation's busy phase.
- Counter width is clog2(W+1); the terminal count is W-1 at the step edge. No wrap is reachable.

Optional Feature:
- MDV_FASTMUL_EN defined: MUL computes i_b * i_c + i_a combinationally and completes at E1.
  - o_done is visible after E1; the MUL state lasts one cycle.
  - DIV timing is unchanged.
- Not defined: iterative W-cycle multiply as described above. Results are bit-identical in both builds.

Test Plan:
- W=16 MUL, a=0x0005, b=0x1234, c=0x0100, cin=1 -> o_done exactly 16 edges after accept (1 with MDV_FASTMUL_EN); hi=0x0012, lo=0x3405, cout=1; o_busy high for 16 cycles.
- W=16 MUL max, a=b=c=0xFFFF, cin=0 -> hi=0xFFFF, lo=0x0000, cout=0.
- W=16 DIV, a=0x0001, b=0x0000, c=0x0003 -> lo=0x5555, hi=0x0001, cout=0, done 16 edges after accept.
- W=16 DIV overflow, a=0x0004, b=0xABCD, c=0x0003 -> done 1 edge after accept, hi=0x0004, lo=0xABCD, cout=1.
- W=16 DIV by zero, a=0x0000, c=0x0000 -> overflow path, cout=1.
- Start during busy plus mid-op reset: second i_start at cycle 5 is ignored (single o_done, first result). Separately, rstn_CHJ low at cycle 8 -> outputs 0, IDLE, no o_done; a fresh op afterwards completes correctly.
- W=8 DIV, a=0x12, b=0x34, c=0x56 -> lo=0x36, hi=0x10, cout=0, done 8 edges after accept.

Source files
------------

// File: rtl/mdv_iter_unit_if.sv
// Handshake and operand bus for mdv_iter_unit.
//   master: drives i_start/i_op/i_a/i_b/i_c/i_cin, observes results.
//   slave : the arithmetic unit; drives o_busy/o_done/o_hi/o_lo/o_cout.
interface mdv_iter_unit_if #(
  parameter int unsigned W = 16
) ();
  logic         i_start;
  logic         i_op;     // 1 = multiply-add, 0 = divide
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic [W-1:0] i_c;
  logic         i_cin;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;
  logic         o_cout;

  modport master (
    output i_start, i_op, i_a, i_b, i_c, i_cin,
    input  o_busy, o_done, o_hi, o_lo, o_cout
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_c, i_cin,
    output o_busy, o_done, o_hi, o_lo, o_cout
  );
endinterface

// File: rtl/mdv_iter_unit.sv
// Iterative multiply-add / divide unit with start/busy/done handshake.
//   MUL: {o_hi, o_lo} = i_b * i_c + i_a, o_cout = i_cin (shift-add, W steps).
//   DIV: {i_a, i_b} / i_c -> o_lo = quotient, o_hi = remainder, o_cout = 0
//        (restoring, W steps); if i_a >= i_c the operands pass through with
//        o_cout = 1 after a single step.
// Ports:
//   clk      - clock, rising edge
//   rstn_CHJ - asynchronous active-low reset
//   bus_io   - mdv_iter_unit_if slave modport (request, operands, results)
// Results hold until the next completion.
// Build option: define MDV_FASTMUL_EN to finish multiply in one step using a
// combinational multiplier; results are identical.
module mdv_iter_unit #(
  parameter int unsigned W = 16
) (
  input logic          clk,
  input logic          rstn_CHJ,
  mdv_iter_unit_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2*W-1:0]  acc_q;    // MUL: running sum; DIV: {remainder, quotient/dividend low}
  logic [2*W-1:0]  mcand_q;  // MUL: multiplicand, shifted left each step
  logic [W-1:0]    opc_q;    // MUL: multiplier, shifted right; DIV: divisor
  logic            cin_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            cout_q;

  logic            last_step;
  assign last_step = (cnt_q == CntW'(W - 1));

`ifdef MDV_FASTMUL_EN
  logic [2*W-1:0] mul_res;
  assign mul_res = ((2*W)'(mcand_q[W-1:0]) * (2*W)'(opc_q)) + acc_q;
`else
  logic [2*W-1:0] mul_step;
  assign mul_step = acc_q + (opc_q[0] ? mcand_q : '0);
`endif

  // Restoring division step: shift {rem, quo} left, trial-subtract divisor.
  logic [W:0]     div_trial;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [W-1:0]   div_rem_nx;
  logic [2*W-1:0] div_next;
  logic           div_ovf;

  assign div_trial  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff   = div_trial - {1'b0, opc_q};
  assign div_ge     = (div_trial >= {1'b0, opc_q});
  assign div_rem_nx = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
  assign div_next   = {div_rem_nx, acc_q[W-2:0], div_ge};
  // Only meaningful on the first step; afterwards remainder < divisor holds.
  assign div_ovf    = (acc_q[2*W-1:W] >= opc_q);

  always_ff @(posedge clk or negedge rstn_CHJ) begin
    if (!rstn_CHJ) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      opc_q   <= '0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_io.i_start) begin
            acc_q   <= bus_io.i_op ? {{W{1'b0}}, bus_io.i_a} : {bus_io.i_a, bus_io.i_b};
            mcand_q <= {{W{1'b0}}, bus_io.i_b};
            opc_q   <= bus_io.i_c;
            cin_q   <= bus_io.i_cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= bus_io.i_op ? StMul : StDiv;
          end
        end
        StMul: begin
`ifdef MDV_FASTMUL_EN
          {hi_q, lo_q} <= mul_res;
          cout_q  <= cin_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
`else
          acc_q   <= mul_step;
          mcand_q <= mcand_q << 1;
          opc_q   <= opc_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_step) begin
            {hi_q, lo_q} <= mul_step;
            cout_q  <= cin_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
`endif
        end
        StDiv: begin
          if ((cnt_q == '0) && div_ovf) begin
            {hi_q, lo_q} <= acc_q;
            cout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CntW'(1);
            if (last_step) begin
              {hi_q, lo_q} <= div_next;
              cout_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.o_busy = busy_q;
  assign bus_io.o_done = done_q;
  assign bus_io.o_hi   = hi_q;
  assign bus_io.o_lo   = lo_q;
  assign bus_io.o_cout = cout_q;

endmodule

// File: tb/tb_mdv_iter_unit.sv
// Directed testbench for mdv_iter_unit (W=16 and W=8 instances).
module tb_mdv_iter_unit;

`ifdef MDV_FASTMUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 16;
`endif

  logic clk = 1'b0;
  logic rstn_CHJ = 1'b0;
  always #5 clk = ~clk;

  mdv_iter_unit_if #(.W(16)) bus16 ();
  mdv_iter_unit_if #(.W(8))  bus8 ();

  mdv_iter_unit #(.W(16)) dut16 (.clk(clk), .rstn_CHJ(rstn_CHJ), .bus_io(bus16));
  mdv_iter_unit #(.W(8))  dut8  (.clk(clk), .rstn_CHJ(rstn_CHJ), .bus_io(bus8));

  int n_checks = 0;
  int n_fail   = 0;

  // Issue one W=16 request and wait for o_done; lat = edges after accept (-1 on timeout).
  task automatic run16(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic cin, output int lat,
                       output int busy_cyc);
    int guard = 0;
    @(negedge clk);
    while ((bus16.o_busy || bus16.o_done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus16.i_op = op; bus16.i_a = a; bus16.i_b = b; bus16.i_c = c; bus16.i_cin = cin;
    bus16.i_start = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands: they must have been latched at accept.
    bus16.i_start = 1'b0;
    bus16.i_a = ~a; bus16.i_b = ~b; bus16.i_c = ~c; bus16.i_cin = ~cin; bus16.i_op = ~op;
    busy_cyc = bus16.o_busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus16.o_done) begin
        lat = i;
        break;
      end
      busy_cyc += bus16.o_busy ? 1 : 0;
    end
  endtask

  task automatic test_reset;
    bus16.i_start = 0; bus16.i_op = 0; bus16.i_a = 0; bus16.i_b = 0; bus16.i_c = 0;
    bus16.i_cin = 0;
    bus8.i_start = 0; bus8.i_op = 0; bus8.i_a = 0; bus8.i_b = 0; bus8.i_c = 0; bus8.i_cin = 0;
    rstn_CHJ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus16.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b expected 0", bus16.o_busy); end
    n_checks++; if (bus16.o_done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b expected 0", bus16.o_done); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== 33'h0) begin n_fail++;
      $display("FAIL reset_result: got %h %h %b expected 0 0 0",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
    @(negedge clk);
    rstn_CHJ = 1'b1;
  endtask

  task automatic test_mul_basic;
    int lat, bc;
    run16(1'b1, 16'h0005, 16'h1234, 16'h0100, 1'b1, lat, bc);
    n_checks++; if (lat !== MulLat) begin n_fail++;
      $display("FAIL mul_latency: got %0d expected %0d", lat, MulLat); end
    n_checks++; if (bc !== MulLat) begin n_fail++;
      $display("FAIL mul_busy_cycles: got %0d expected %0d", bc, MulLat); end
    n_checks++; if (bus16.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL mul_busy_in_done: got %b expected 0", bus16.o_busy); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'h0012, 16'h3405, 1'b1})
      begin n_fail++;
      $display("FAIL mul_result: got %h %h %b expected 0012 3405 1",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
    @(posedge clk);
    #1;
    n_checks++; if (bus16.o_done !== 1'b0) begin n_fail++;
      $display("FAIL done_one_cycle: got %b expected 0", bus16.o_done); end
    n_checks++; if (bus16.o_lo !== 16'h3405) begin n_fail++;
      $display("FAIL mul_hold_idle: got %h expected 3405", bus16.o_lo); end
  endtask

  task automatic test_mul_max;
    int lat, bc;
    run16(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, lat, bc);
    n_checks++; if (lat !== MulLat) begin n_fail++;
      $display("FAIL mulmax_latency: got %0d expected %0d", lat, MulLat); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'hFFFF, 16'h0000, 1'b0})
      begin n_fail++;
      $display("FAIL mulmax_result: got %h %h %b expected ffff 0000 0",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
  endtask

  task automatic test_div_basic;
    int lat, bc;
    run16(1'b0, 16'h0001, 16'h0000, 16'h0003, 1'b1, lat, bc);
    n_checks++; if (lat !== 16) begin n_fail++;
      $display("FAIL div_latency: got %0d expected 16", lat); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'h0001, 16'h5555, 1'b0})
      begin n_fail++;
      $display("FAIL div_result: got %h %h %b expected 0001 5555 0",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
  endtask

  task automatic test_div_overflow;
    int lat, bc;
    run16(1'b0, 16'h0004, 16'hABCD, 16'h0003, 1'b0, lat, bc);
    n_checks++; if (lat !== 1) begin n_fail++;
      $display("FAIL divovf_latency: got %0d expected 1", lat); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'h0004, 16'hABCD, 1'b1})
      begin n_fail++;
      $display("FAIL divovf_result: got %h %h %b expected 0004 abcd 1",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
    // Boundary: i_a == i_c also overflows.
    run16(1'b0, 16'h0003, 16'h1111, 16'h0003, 1'b0, lat, bc);
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout, lat} !== {16'h0003, 16'h1111, 1'b1, 1})
      begin n_fail++;
      $display("FAIL divovf_equal: got %h %h %b lat %0d expected 0003 1111 1 lat 1",
               bus16.o_hi, bus16.o_lo, bus16.o_cout, lat); end
  endtask

  task automatic test_div_by_zero;
    int lat, bc;
    run16(1'b0, 16'h0000, 16'h1357, 16'h0000, 1'b0, lat, bc);
    n_checks++; if (lat !== 1) begin n_fail++;
      $display("FAIL divzero_latency: got %0d expected 1", lat); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'h0000, 16'h1357, 1'b1})
      begin n_fail++;
      $display("FAIL divzero_result: got %h %h %b expected 0000 1357 1",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
  endtask

  task automatic test_start_during_busy;
    int dones = 0;
    int lat = -1;
    logic [32:0] res = '0;
    @(negedge clk);
    @(negedge clk);
    bus16.i_op = 1'b0; bus16.i_a = 16'h0001; bus16.i_b = 16'h0000; bus16.i_c = 16'h0003;
    bus16.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus16.i_start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) begin
        bus16.i_op = 1'b1; bus16.i_a = 16'h0007; bus16.i_b = 16'h0002; bus16.i_c = 16'h0002;
        bus16.i_start = 1'b1;
      end
      if (i == 5) bus16.i_start = 1'b0;
      if (i == 8) begin
        // Previous (divide-by-zero) result must still be held while busy.
        n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== {16'h0000, 16'h1357, 1'b1})
          begin n_fail++;
          $display("FAIL hold_while_busy: got %h %h %b expected 0000 1357 1",
                   bus16.o_hi, bus16.o_lo, bus16.o_cout); end
      end
      if (bus16.o_done) begin
        dones++;
        if (lat < 0) begin
          lat = i;
          res = {bus16.o_hi, bus16.o_lo, bus16.o_cout};
        end
      end
    end
    n_checks++; if (dones !== 1) begin n_fail++;
      $display("FAIL busy_start_done_count: got %0d expected 1", dones); end
    n_checks++; if (lat !== 16) begin n_fail++;
      $display("FAIL busy_start_latency: got %0d expected 16", lat); end
    n_checks++; if (res !== {16'h0001, 16'h5555, 1'b0}) begin n_fail++;
      $display("FAIL busy_start_result: got %h expected %h", res, {16'h0001, 16'h5555, 1'b0}); end
  endtask

  task automatic test_mid_op_reset;
    int dones = 0;
    int lat, bc;
    @(negedge clk);
    bus16.i_op = 1'b1; bus16.i_a = 16'h0005; bus16.i_b = 16'h1234; bus16.i_c = 16'h0100;
    bus16.i_cin = 1'b1;
    bus16.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus16.i_start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rstn_CHJ = 1'b0;
    #1;
    n_checks++; if ({bus16.o_busy, bus16.o_done} !== 2'b00) begin n_fail++;
      $display("FAIL midreset_flags: got busy %b done %b expected 0 0",
               bus16.o_busy, bus16.o_done); end
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout} !== 33'h0) begin n_fail++;
      $display("FAIL midreset_result: got %h %h %b expected 0 0 0",
               bus16.o_hi, bus16.o_lo, bus16.o_cout); end
    @(negedge clk);
    rstn_CHJ = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (bus16.o_done || bus16.o_busy) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++;
      $display("FAIL midreset_no_done: got %0d active cycles expected 0", dones); end
    run16(1'b1, 16'h0005, 16'h1234, 16'h0100, 1'b1, lat, bc);
    n_checks++; if ({bus16.o_hi, bus16.o_lo, bus16.o_cout, lat} !== {16'h0012, 16'h3405, 1'b1, MulLat})
      begin n_fail++;
      $display("FAIL midreset_fresh_op: got %h %h %b lat %0d expected 0012 3405 1 lat %0d",
               bus16.o_hi, bus16.o_lo, bus16.o_cout, lat, MulLat); end
  endtask

  task automatic test_div_w8;
    int lat = -1;
    @(negedge clk);
    bus8.i_op = 1'b0; bus8.i_a = 8'h12; bus8.i_b = 8'h34; bus8.i_c = 8'h56; bus8.i_cin = 1'b1;
    bus8.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus8.i_start = 1'b0;
    bus8.i_a = 8'hFF; bus8.i_b = 8'hFF; bus8.i_c = 8'h01;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus8.o_done) begin
        lat = i;
        break;
      end
    end
    n_checks++; if (lat !== 8) begin n_fail++;
      $display("FAIL w8_div_latency: got %0d expected 8", lat); end
    n_checks++; if ({bus8.o_hi, bus8.o_lo, bus8.o_cout} !== {8'h10, 8'h36, 1'b0}) begin n_fail++;
      $display("FAIL w8_div_result: got %h %h %b expected 10 36 0",
               bus8.o_hi, bus8.o_lo, bus8.o_cout); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div_basic();
    test_div_overflow();
    test_div_by_zero();
    test_start_during_busy();
    test_mid_op_reset();
    test_div_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
